// File: rtl/a2d_spi_resp.sv
// SPI responder for the A2D two-frame channel read: a command frame selects a channel,
// the following response frame shifts that channel's 12-bit result back to the master.
module a2d_spi_resp #(
  parameter logic [11:0] RST_DATA    = 12'h000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic        wr_en,
  input  logic [2:0]  wr_chnnl,
  input  logic [11:0] wr_data,
  output logic [2:0]  chnnl_last,
  output logic        xact_done,
  output logic        cmd_err,
  output logic        frm_err
);

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic {CMD, RESP} phase_t;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic                   ss_d, sclk_d;
  logic                   ss_s, sclk_s, mosi_s;
  logic                   ss_fall, ss_rise, sclk_rise, sclk_fall;

  state_t      state_q, state_d;
  phase_t      phase;
  logic [4:0]  cnt;
  logic [15:0] rx;
  logic [15:0] tx;
  logic [11:0] snap;
  logic [11:0] regfile [8];

  // Synchronizers are left unreset so a reset while SS_n is low cannot fake an SS_n edge.
  always_ff @(posedge clk) begin
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    ss_d      <= ss_s;
    sclk_d    <= sclk_s;
  end

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_fall   = ss_d & ~ss_s;
  assign ss_rise   = ~ss_d & ss_s;
  assign sclk_rise = ~sclk_d & sclk_s;
  assign sclk_fall = sclk_d & ~sclk_s;

  assign MISO = tx[15] & ~ss_s;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ss_fall) state_d = SHIFT;
      SHIFT:   if (ss_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase      <= CMD;
      cnt        <= 5'd0;
      rx         <= 16'h0000;
      tx         <= 16'h0000;
      snap       <= 12'h000;
      chnnl_last <= 3'b000;
      xact_done  <= 1'b0;
      cmd_err    <= 1'b0;
      frm_err    <= 1'b0;
      for (int i = 0; i < 8; i++) regfile[i] <= RST_DATA;
    end else begin
      xact_done <= 1'b0;
      cmd_err   <= 1'b0;
      frm_err   <= 1'b0;
      // Snapshot below reads regfile before this write lands, giving pre-write data on a collision.
      if (wr_en) regfile[wr_chnnl] <= wr_data;
      case (state_q)
        IDLE: begin
          if (ss_fall) begin
            cnt <= 5'd0;
            tx  <= (phase == RESP) ? {4'h0, snap} : 16'h0000;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            if (cnt != 5'd16) begin
              frm_err <= 1'b1;
            end else if (phase == CMD) begin
              chnnl_last <= rx[13:11];
              snap       <= regfile[rx[13:11]];
              phase      <= RESP;
              cmd_err    <= (rx[15:14] != 2'b00) || (rx[10:0] != 11'h000);
            end else begin
              xact_done <= 1'b1;
              phase     <= CMD;
            end
          end else begin
            if (sclk_rise) begin
              rx  <= {rx[14:0], mosi_s};
              cnt <= (cnt == 5'd17) ? 5'd17 : cnt + 5'd1;
            end
            if (sclk_fall) tx <= {tx[14:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Bench for a2d_spi_resp: SPI master tasks drive frames, a frame-level model queues expected
// pulse events, and a monitor process matches every DUT pulse against that queue.
module tb_a2d_spi_resp;

  // Non-zero reset value so reset-state reads are distinguishable from an all-zero register.
  localparam logic [11:0] RST = 12'h3C5;
  localparam logic [2:0]  K_X = 3'b100;
  localparam logic [2:0]  K_C = 3'b010;
  localparam logic [2:0]  K_F = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n, SS_n, SCLK, MOSI, MISO, wr_en;
  logic [2:0]  wr_chnnl, chnnl_last;
  logic [11:0] wr_data;
  logic        xact_done, cmd_err, frm_err;

  a2d_spi_resp #(.RST_DATA(RST), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .wr_en(wr_en), .wr_chnnl(wr_chnnl), .wr_data(wr_data), .chnnl_last(chnnl_last),
    .xact_done(xact_done), .cmd_err(cmd_err), .frm_err(frm_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  kind;
    logic [2:0]  ch;
    logic [15:0] data;
  } ev_t;

  ev_t         exq[$];
  int          nchk = 0;
  int          nerr = 0;
  logic [15:0] last_rd = 16'h0;

  // Frame-level reference model
  logic [11:0] mreg [8];
  logic        m_resp;
  logic [11:0] m_snap;
  logic [2:0]  m_last;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mreg[i] = RST;
    m_resp = 1'b0;
    m_snap = 12'h000;
    m_last = 3'd0;
  endtask

  task automatic model_frame(input logic [15:0] cmd, input int nrise);
    ev_t e;
    if (nrise != 16) begin
      e.kind = K_F; e.ch = m_last; e.data = 16'h0; exq.push_back(e);
    end else if (!m_resp) begin
      m_last = cmd[13:11];
      m_snap = mreg[cmd[13:11]];
      m_resp = 1'b1;
      if (cmd[15:14] != 2'b00 || cmd[10:0] != 11'h000) begin
        e.kind = K_C; e.ch = m_last; e.data = 16'h0; exq.push_back(e);
      end
    end else begin
      e.kind = K_X; e.ch = m_last; e.data = {4'h0, m_snap}; exq.push_back(e);
      m_resp = 1'b0;
    end
  endtask

  // Master drives MOSI on SCLK fall and captures MISO just before each fall.
  task automatic frame(input logic [15:0] cmd, input int nrise);
    logic [15:0] sh, got;
    sh = cmd; got = 16'h0;
    SS_n = 1'b0;
    clks(6);
    for (int i = 0; i < nrise; i++) begin
      got = {got[14:0], MISO};
      SCLK = 1'b0; MOSI = sh[15]; sh = sh << 1;
      clks(4);
      SCLK = 1'b1;
      clks(4);
    end
    last_rd = got;
    model_frame(cmd, nrise);
    SS_n = 1'b1;
    clks(8);
  endtask

  task automatic pair(input logic [2:0] ch);
    frame({2'b00, ch, 11'h000}, 16);
    frame(16'h0000, 16);
  endtask

  task automatic host_wr(input logic [2:0] ch, input logic [11:0] d);
    wr_en = 1'b1; wr_chnnl = ch; wr_data = d;
    clks(1);
    wr_en = 1'b0;
    mreg[ch] = d;
  endtask

  // Monitor: every pulse cycle pops one expected event
  initial begin
    ev_t e;
    logic [2:0] p;
    forever begin
      @(negedge clk);
      p = {xact_done, cmd_err, frm_err};
      if (rst_n === 1'b1 && p != 3'b000) begin
        if (exq.size() == 0) begin
          chk("unexpected_pulse", {29'h0, p}, 32'h0);
        end else begin
          e = exq.pop_front();
          chk("pulse_kind", {29'h0, p}, {29'h0, e.kind});
          chk("chnnl_last", {29'h0, chnnl_last}, {29'h0, e.ch});
          if (e.kind == K_X) chk("resp_data", {16'h0, last_rd}, {16'h0, e.data});
        end
      end
    end
  end

  initial begin
    logic [15:0] c;
    int r;
    rst_n = 1'b0; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
    wr_en = 1'b0; wr_chnnl = 3'd0; wr_data = 12'h0;
    model_reset();
    clks(5);
    rst_n = 1'b1;
    clks(2);
    chk("rst_miso", {31'h0, MISO}, 32'h0);
    chk("rst_chnnl_last", {29'h0, chnnl_last}, 32'h0);
    chk("rst_pulses", {29'h0, xact_done, cmd_err, frm_err}, 32'h0);

    pair(3'd5);
    host_wr(3'd3, 12'hABC);
    frame(16'h1800, 16);
    frame(16'h0000, 16);
    host_wr(3'd0, 12'h111);
    host_wr(3'd7, 12'hFFF);
    pair(3'd7);
    pair(3'd0);
    host_wr(3'd2, 12'h123);
    frame(16'h1000, 16);
    host_wr(3'd2, 12'h456);
    frame(16'h0000, 16);
    pair(3'd2);
    frame(16'h0800, 8);
    pair(3'd1);
    frame(16'hC800, 16);
    frame(16'h0000, 16);

    // Reset partway through a response frame
    frame(16'h2000, 16);
    SS_n = 1'b0;
    clks(6);
    for (int i = 0; i < 6; i++) begin
      SCLK = 1'b0; MOSI = 1'b0; clks(4);
      SCLK = 1'b1; clks(4);
    end
    rst_n = 1'b0;
    clks(3);
    rst_n = 1'b1;
    model_reset();
    clks(1);
    chk("midrst_miso", {31'h0, MISO}, 32'h0);
    chk("midrst_chnnl_last", {29'h0, chnnl_last}, 32'h0);
    SS_n = 1'b1;
    clks(8);
    pair(3'd6);
    pair(3'd3);

    for (int n = 0; n < 30; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3) begin
        host_wr(3'($urandom_range(0, 7)), 12'($urandom));
      end else if (r < 8) begin
        c = {2'b00, 3'($urandom_range(0, 7)), 11'h000};
        if ($urandom_range(0, 4) == 0) c = 16'($urandom);
        frame(c, 16);
      end else begin
        r = $urandom_range(0, 19);
        frame(16'($urandom), (r >= 16) ? r + 1 : r);
      end
    end
    if (m_resp) frame(16'h0000, 16);

    for (int t = 0; t < 50 && exq.size() != 0; t++) clks(1);
    while (exq.size() != 0) begin
      ev_t e;
      e = exq.pop_front();
      chk("missing_pulse", 32'h0, {29'h0, e.kind});
    end
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
